// File: rtl/mac_tc_array_if.sv
// Operand/result bundle for the mac_tc_array tensor-core cube.
// A and B carry skewed operand wavefronts; result carries column-major C lanes.
interface mac_tc_array_if #(
   parameter int N         = 8,
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH+$clog2(N)
);
   logic [N*N*WIDTH-1:0]     A;
   logic [N*N*WIDTH-1:0]     B;
   logic [N*N*ACC_WIDTH-1:0] result;

   modport master (output A, output B, input result);
   modport slave  (input A, input B, output result);
endinterface

// File: rtl/mac_tc_array.sv
// Fully pipelined signed N x N matrix-multiply cube: A flows across columns,
// B flows down rows, and each PE reduces its k-depth in an N-stage adder chain.
module mac_tc_delay #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] signal,
   output logic [W-1:0] pipeline_signal
);
   logic [W-1:0] stage_q [DEPTH];
   logic [W-1:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = signal;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      end
   end

   assign pipeline_signal = stage_q[DEPTH-1];
endmodule

module mac_tc_pe #(
   parameter int N         = 8,
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH+$clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   a,
   input  logic [N*WIDTH-1:0]   b,
   output logic [ACC_WIDTH-1:0] psum
);
   logic signed [ACC_WIDTH-1:0] p_q [N];
   logic signed [ACC_WIDTH-1:0] p_d [N];

   // Operands are sign-extended before multiplying so the product wraps at ACC_WIDTH.
   function automatic logic signed [ACC_WIDTH-1:0] mul(input logic [WIDTH-1:0] x,
                                                        input logic [WIDTH-1:0] y);
      return ACC_WIDTH'($signed(x)) * ACC_WIDTH'($signed(y));
   endfunction

   always_comb begin
      p_d[0] = mul(a[0 +: WIDTH], b[0 +: WIDTH]);
      for (int k = 1; k < N; k++)
         p_d[k] = p_q[k-1] + mul(a[k*WIDTH +: WIDTH], b[k*WIDTH +: WIDTH]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) p_q[k] <= '0;
      end else begin
         for (int k = 0; k < N; k++) p_q[k] <= p_d[k];
      end
   end

   assign psum = p_q[N-1];
endmodule

module mac_tc_array #(
   parameter int N         = 8,
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH+$clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   mac_tc_array_if.slave io
);
   logic [N*WIDTH-1:0] a_q [N][N];
   logic [N*WIDTH-1:0] b_q [N][N];

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         logic [N*WIDTH-1:0] a_src;
         logic [N*WIDTH-1:0] b_src;

         // Column 0 / row 0 take the skewed input lanes; the rest forward their neighbour.
         if (c == 0) begin : g_a_in
            assign a_src = io.A[N*WIDTH*r +: N*WIDTH];
         end else begin : g_a_fwd
            assign a_src = a_q[r][c-1];
         end
         if (r == 0) begin : g_b_in
            assign b_src = io.B[N*WIDTH*c +: N*WIDTH];
         end else begin : g_b_fwd
            assign b_src = b_q[r-1][c];
         end

         mac_tc_delay #(.DEPTH(1), .W(N*WIDTH)) u_a_dly (
            .clk(clk), .rst_n(rst_n), .signal(a_src), .pipeline_signal(a_q[r][c]));
         mac_tc_delay #(.DEPTH(1), .W(N*WIDTH)) u_b_dly (
            .clk(clk), .rst_n(rst_n), .signal(b_src), .pipeline_signal(b_q[r][c]));

         mac_tc_pe #(.N(N), .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .a     (a_q[r][c]),
            .b     (b_q[r][c]),
            .psum  (io.result[ACC_WIDTH*(c*N+r) +: ACC_WIDTH])
         );
      end
   end
endmodule

// File: tb/tb_mac_tc_array.sv
// Random-stream bench for mac_tc_array: skewed operand driver plus a plain GEMM
// reference; also exercises the delay-line helper standalone.
module tb_mac_tc_array;
   localparam int N     = 8;
   localparam int WIDTH = 8;
   localparam int ACC_W = 2*WIDTH+$clog2(N);
   localparam int KMAX  = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mac_tc_array_if #(.N(N), .WIDTH(WIDTH), .ACC_WIDTH(ACC_W)) bus ();
   mac_tc_array #(.N(N), .WIDTH(WIDTH), .ACC_WIDTH(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .io(bus.slave));

   logic       d8_in  = 1'b0;
   logic       d8_out;
   logic [7:0] d1_in  = 8'h00;
   logic [7:0] d1_out;
   mac_tc_delay #(.DEPTH(8), .W(1)) u_d8 (
      .clk(clk), .rst_n(rst_n), .signal(d8_in), .pipeline_signal(d8_out));
   mac_tc_delay #(.DEPTH(1), .W(8)) u_d1 (
      .clk(clk), .rst_n(rst_n), .signal(d1_in), .pipeline_signal(d1_out));

   int n_tests = 0;
   int n_fail  = 0;
   int a_m [KMAX][N][N];
   int b_m [KMAX][N][N];
   int c_m [KMAX][N][N];
   int k_len = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int lane_val(input int r, input int c);
      logic signed [ACC_W-1:0] v;
      v = bus.result[ACC_W*(c*N+r) +: ACC_W];
      return int'(v);
   endfunction

   function automatic logic [N*N*WIDTH-1:0] rand_vec();
      logic [N*N*WIDTH-1:0] v;
      for (int i = 0; i < N*N*WIDTH/32; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   function automatic int rnd8();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   task automatic gemm();
      for (int z = 0; z < k_len; z++)
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               int s = 0;
               for (int k = 0; k < N; k++) s += a_m[z][r][k] * b_m[z][k][c];
               c_m[z][r][c] = s;
            end
   endtask

   // Lanes carry matrix z = e - (row/col) - k when that index lies in the stream.
   task automatic drive(input int e);
      logic [N*N*WIDTH-1:0] va = '0;
      logic [N*N*WIDTH-1:0] vb = '0;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            int z = e - i - k;
            if (z >= 0 && z < k_len) begin
               va[WIDTH*(i*N+k) +: WIDTH] = 8'(a_m[z][i][k]);
               vb[WIDTH*(i*N+k) +: WIDTH] = 8'(b_m[z][k][i]);
            end
         end
      bus.A = va;
      bus.B = vb;
   endtask

   task automatic check_all(input string tag, input int e);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            int z = e - r - c - N;
            int exp = (z >= 0 && z < k_len) ? c_m[z][r][c] : 0;
            chk($sformatf("%s e%0d r%0d c%0d", tag, e, r, c), lane_val(r, c), exp);
         end
   endtask

   task automatic run_stream(input string tag);
      gemm();
      for (int e = 0; e <= k_len + 3*N; e++) begin
         @(negedge clk);
         drive(e);
         @(posedge clk);
         #1;
         check_all(tag, e);
      end
   endtask

   initial begin
      bus.A = '0;
      bus.B = '0;

      // Reset held with garbage on the operand lanes.
      k_len = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.A = rand_vec();
         bus.B = rand_vec();
         @(posedge clk);
         #1;
         check_all("rst_hold", 0);
      end
      @(negedge clk);
      bus.A = '0;
      bus.B = '0;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_all("zero_in", 0);
      end

      // Mid-stream reset: outputs must clear without waiting for an edge.
      k_len = KMAX;
      for (int z = 0; z < KMAX; z++)
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               a_m[z][r][c] = rnd8();
               b_m[z][r][c] = rnd8();
            end
      gemm();
      for (int e = 0; e < 16; e++) begin
         @(negedge clk);
         drive(e);
         @(posedge clk);
         #1;
         check_all("pre_abort", e);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      k_len = 0;
      check_all("mid_rst", 0);
      @(negedge clk);
      bus.A = '0;
      bus.B = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Identity A reproduces B.
      k_len = 1;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a_m[0][r][c] = (r == c) ? 1 : 0;
            b_m[0][r][c] = rnd8();
         end
      run_stream("ident");

      // Extreme operands.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a_m[0][r][c] = -128;
            b_m[0][r][c] = -128;
         end
      run_stream("neg_neg");
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) a_m[0][r][c] = 127;
      run_stream("pos_neg");

      // Long random streams: 10 B sets x 10 A sets.
      k_len = KMAX;
      for (int bs = 0; bs < 10; bs++) begin
         for (int z = 0; z < KMAX; z++)
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++) b_m[z][r][c] = rnd8();
         for (int as = 0; as < 10; as++) begin
            for (int z = 0; z < KMAX; z++)
               for (int r = 0; r < N; r++)
                  for (int c = 0; c < N; c++) a_m[z][r][c] = rnd8();
            run_stream($sformatf("rand b%0d a%0d", bs, as));
         end
      end

      // Back-to-back: all-ones then all-twos.
      k_len = 2;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a_m[0][r][c] = 1;
            b_m[0][r][c] = 1;
            a_m[1][r][c] = 2;
            b_m[1][r][c] = 2;
         end
      run_stream("b2b");

      // Delay-line helper standalone.
      @(negedge clk);
      d8_in = 1'b1;
      d1_in = 8'hA5;
      @(posedge clk);
      #1;
      chk("dly1_a5", int'(d1_out), 32'hA5);
      chk("dly8 i0", int'(d8_out), 0);
      @(negedge clk);
      d8_in = 1'b0;
      d1_in = 8'h3C;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("dly8 i%0d", i), int'(d8_out), (i == 7) ? 1 : 0);
         if (i == 1) chk("dly1_3c", int'(d1_out), 32'h3C);
         if (i == 1) begin
            @(negedge clk);
            d1_in = 8'hA5;
         end
      end
      #2 rst_n = 1'b0;
      #1;
      chk("dly1_rst", int'(d1_out), 0);
      chk("dly8_rst", int'(d8_out), 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mac_tc_array.md
Name: mac_tc_array

Overview:
- Output-stationary-free, fully pipelined signed integer N×N matrix-multiply array (tensor-core cube).
- Each cycle it accepts one skewed wavefront of A and B operands and streams out one C = A·B product per matrix. Results of consecutive matrices z = 0,1,2,… emerge back-to-back with no accumulation across matrices.
- Operands travel through an internal parameterised delay-line helper; the design has no valid or clear inputs.

Parameters:
- N, 8, matrix dimension and reduction length (rows, columns, and k-depth of each PE).
- WIDTH, 8, signed operand width.
- ACC_WIDTH, 2*WIDTH+$clog2(N) (=19), signed result width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  N*N*WIDTH  signed A operands. Lane r*N+k (bits [WIDTH*(r*N+k) +: WIDTH]) carries A[r][k].
- B  input  N*N*WIDTH  signed B operands. Lane c*N+k carries B[k][c] (column-major).
- result  output  N*N*ACC_WIDTH  lane c*N+r (bits [ACC_WIDTH*(c*N+r) +: ACC_WIDTH]) carries C[r][c] (column-major).

Behaviour:
- Reset: asynchronous, rst_n low clears every register (operand skew regs, partial sums) to 0. result reads 0 while in reset and until new data drains through. Reset mid-stream discards all in-flight matrices.
- Structure: N×N PEs, PE(r,c), each with N multiply stages k = 0..N-1.
- A path: a[r][0][k] <= A lane r*N+k; a[r][c][k] <= a[r][c-1][k]. A moves one column per cycle.
- B path: b[0][c][k] <= B lane c*N+k; b[r][c][k] <= b[r-1][c][k]. B moves one row per cycle.
- Reduction chain:
  - p[r][c][0] <= a[r][c][0]*b[r][c][0].
  - p[r][c][k] <= p[r][c][k-1] + a[r][c][k]*b[r][c][k].
  - result lane c*N+r = p[r][c][N-1], driven directly from the register with no extra output stage.
- Arithmetic: products are signed WIDTH×WIDTH, sign-extended to ACC_WIDTH; sums wrap two's-complement at ACC_WIDTH. Default width never overflows.
- Input skew contract: for matrix z, A lane r*N+k holds A_z[r][k] in the cycle sampled at edge t0+z+r+k. B lane c*N+k holds B_z[k][c] at edge t0+z+c+k. Lanes outside their window are driven 0.
- Latency: result lane c*N+r equals C_z[r][c] = Σk A_z[r][k]·B_z[k][c] in the cycle following edge t0+z+r+c+N. It holds for exactly one cycle, then carries C_{z+1}[r][c].
- Throughput: one matrix per cycle, unlimited stream length K. Zero inputs produce zero outputs after at most 3N cycles of drain.
- Delay-line helper:
  - Parameters DEPTH (N), W (WIDTH). Ports clk, rst_n, signal[W], pipeline_signal[W].
  - Output is input delayed DEPTH register stages, asynchronously reset to 0.
  - DEPTH=1 gives a single flop.

Test Plan:
1. Hold rst_n low 9 cycles with random A/B → result all 0. Release, drive zeros → result stays 0. Assert rst_n mid-stream → all lanes 0 immediately.
2. K=1, A=identity, B random with the skew contract → lane c*N+r equals B[r][c] after edge t0+r+c+N, and 0 one cycle later.
3. K=1, all A=B=-128 → every lane = 131072 at its slot. All A=127, B=-128 → every lane = -130048.
4. K=32 random int8 stream, 100 iterations (10 B sets × 10 A sets) → every C_z[r][c] matches the software GEMM at edge t0+z+r+c+N. Zeroed drain of 2N+K cycles between iterations gives no cross-matrix contamination.
5. Two matrices back-to-back (z=0 with all-ones, z=1 with all-twos) → lane 0 shows 8 then 32 on consecutive cycles.
6. Delay-line helper with DEPTH=8, W=1: single-cycle pulse → output pulse exactly 8 cycles later. With DEPTH=1, W=8 and value 0xA5 → output 0xA5 next cycle. Reset → 0.
